// File: rtl/display_pkg.sv
// Shared constants, state encoding and BCD helper for the seven-segment scan controller.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_e;

    function automatic logic is_bcd(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/BinaryToSevenSeg_GL.sv
// Combinational BCD to seven-segment decoder, active-low segments, seg[0]=a .. seg[6]=g.
module BinaryToSevenSeg_GL
    import display_pkg::*;
(
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    // Segment lookup; non-BCD codes produce a dark pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (bin)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered display value
// that is only promoted at frame boundaries (or immediately while the display is dark).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DRIVE_CYC  = 1000,
    parameter int GUARD_CYC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_val,
    output logic                    wr_rdy,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int MAX_CYC = (DRIVE_CYC > GUARD_CYC) ? DRIVE_CYC : GUARD_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int DW      = 4 * NUM_DIGITS;

    scan_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         active_q, active_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  frame_end_s;
    logic [3:0]            cur_nib_s;
    logic [6:0]            dec_seg_s;

    assign cur_nib_s = active_q[{idx_q, 2'b00} +: 4];

    BinaryToSevenSeg_GL u_dec (
        .bin (cur_nib_s),
        .seg (dec_seg_s)
    );

    // Scan sequencing: OFF -> DRIVE/GUARD per digit, en low forces OFF from any state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        frame_end_s = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                ST_DRIVE: begin
                    if (cnt_q == CW'(DRIVE_CYC - 1)) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == CW'(GUARD_CYC - 1)) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                        if (idx_q == IW'(NUM_DIGITS - 1)) begin
                            idx_d       = '0;
                            frame_end_s = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Double buffer: accept into pending when empty, promote at frame end or while dark.
    always_comb begin
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (pend_vld_q && (!en || frame_end_s)) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
        end else if (wr_val && !pend_vld_q) begin
            pend_d     = wr_data;
            pend_vld_d = 1'b1;
        end else begin
            pend_vld_d = pend_vld_q;
        end
    end

    // Pin values for the next cycle; gating on en darkens the display one cycle after en drops.
    always_comb begin
        an_d         = '1;
        seg_d        = SEG_BLANK;
        frame_done_d = frame_end_s;
        if (en && (state_q == ST_DRIVE)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = is_bcd(cur_nib_s) ? dec_seg_s : SEG_BLANK;
        end else begin
            an_d  = '1;
            seg_d = SEG_BLANK;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_rdy     = ~pend_vld_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus randomized bench for display_scan_ctrl against a frame-position reference model.
module tb_display_scan_ctrl;

    localparam int N = 4;
    localparam int D = 4;
    localparam int G = 2;
    localparam int S = D + G;
    localparam int F = N * S;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_val;
    logic [15:0] wr_data;
    logic        wr_rdy;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    display_scan_ctrl #(.NUM_DIGITS(N), .DRIVE_CYC(D), .GUARD_CYC(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_val     (wr_val),
        .wr_rdy     (wr_rdy),
        .wr_data    (wr_data),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: scanning flag, position within the frame, and the two buffers.
    bit          m_on;
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    bit          m_pvld;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'd0:    lit = 7'b0111111;
            4'd1:    lit = 7'b0000110;
            4'd2:    lit = 7'b1011011;
            4'd3:    lit = 7'b1001111;
            4'd4:    lit = 7'b1100110;
            4'd5:    lit = 7'b1101101;
            4'd6:    lit = 7'b1111101;
            4'd7:    lit = 7'b0000111;
            4'd8:    lit = 7'b1111111;
            4'd9:    lit = 7'b1101111;
            default: lit = 7'b0000000;
        endcase
        return ~lit;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0;
        m_t = 0;
        m_active = 16'h0000;
        m_pend = 16'h0000;
        m_pvld = 1'b0;
    endtask

    // One clock: advance the model with the inputs that the edge samples, then compare pins.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic [3:0] one;
        bit         fd;
        bit         acc;
        int         digit;
        int         phase;
        @(posedge clk);
        one   = 4'b0001;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        fd    = 1'b0;
        acc   = wr_val && !m_pvld;
        if (en && m_on) begin
            digit = m_t / S;
            phase = m_t % S;
            if (phase < D) begin
                e_an  = ~(one << digit);
                e_seg = seg_of(m_active[digit*4 +: 4]);
            end
            fd = (m_t == F - 1);
        end
        if (m_pvld && (!en || fd)) begin
            m_active = m_pend;
            m_pvld   = 1'b0;
        end else if (acc) begin
            m_pend = wr_data;
            m_pvld = 1'b1;
        end
        if (!en) begin
            m_on = 1'b0;
            m_t  = 0;
        end else if (!m_on) begin
            m_on = 1'b1;
            m_t  = 0;
        end else begin
            m_t = (m_t + 1) % F;
        end
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("wr_rdy", 32'(wr_rdy), 32'(!m_pvld));
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_wr_rdy"}, 32'(wr_rdy), 32'h1);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        wr_val = 1'b0;
        wr_data = 16'h0000;
        model_reset();
        #12;
        check_dark("reset");
        @(negedge clk);
        rst = 1'b0;

        // Write while dark: promoted the cycle after acceptance.
        wr_val = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_val = 1'b0;
        step();
        chk("dark_promote", 32'(dut.active_q), 32'h1234);

        // Full frames of 1234.
        en = 1'b1;
        repeat (F + 2) step();

        // Mid-frame overwrite with 5678.
        repeat (5) step();
        wr_val = 1'b1;
        wr_data = 16'h5678;
        step();
        wr_val = 1'b0;
        repeat (2 * F) step();

        // Write held across the promotion cycle, including non-BCD nibbles.
        wr_val = 1'b1;
        wr_data = 16'h9A0B;
        step();
        wr_data = 16'hC3F1;
        repeat (2 * F + 3) step();
        wr_val = 1'b0;
        repeat (F) step();

        // Async reset in the middle of digit 2's drive window.
        for (int i = 0; i < F; i++) begin
            if (m_on && (m_t == 2 * S + 1)) break;
            step();
        end
        chk("pre_reset_an", 32'(an), 32'hB);
        #2;
        rst = 1'b1;
        #1;
        check_dark("mid_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wr_val = 1'b1;
        wr_data = 16'h8E07;
        step();
        wr_val = 1'b0;
        repeat (2 * F) step();

        // Drop en at the start of a guard window, then re-enable.
        for (int i = 0; i < F; i++) begin
            if (m_on && ((m_t % S) == D)) break;
            step();
        end
        en = 1'b0;
        step();
        repeat (3) step();
        en = 1'b1;
        repeat (F + 2) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 29) != 0);
            wr_val = ($urandom_range(0, 3) == 0);
            wr_data = 16'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
